// File: rtl/aq_axi_sdma64_intctl_pkg.sv
// rtl/aq_axi_sdma64_intctl_pkg.sv - shared constants and types for the SDMA64 interrupt controller
package aq_axi_sdma64_intctl_pkg;

  localparam logic [1:0] ADDR_STATUS   = 2'd0;
  localparam logic [1:0] ADDR_MASK     = 2'd1;
  localparam logic [1:0] ADDR_COAL_CFG = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  localparam int CTRL_GIE   = 0;
  localparam int CTRL_FORCE = 1;

  localparam int THR_RST = 1;
  localparam int TMO_RST = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FIRE  = 2'd2
  } coal_state_t;

endpackage

// File: rtl/aq_axi_sdma64_intctl_coal.sv
// rtl/aq_axi_sdma64_intctl_coal.sv - coalescing FSM with saturating event counter and timeout timer
module aq_axi_sdma64_intctl_coal
  import aq_axi_sdma64_intctl_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt,
  input  logic             pending,
  input  logic [CNT_W-1:0] thr,
  input  logic [TMO_W-1:0] tmo,
  output logic             fire,
  output logic [CNT_W-1:0] count
);

  coal_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic [CNT_W:0]   count_sum;
  logic             count_hit, tmo_hit;

  assign count_sum = {1'b0, count_q} + {{CNT_W{1'b0}}, evt};
  assign count_hit = count_sum >= {1'b0, thr};
  assign tmo_hit   = (tmo != '0) && (timer_q == tmo - TMO_W'(1));
  assign count_inc = (evt && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (evt) begin
          count_d = CNT_W'(1);
          timer_d = '0;
          state_d = (thr <= CNT_W'(1)) ? ST_FIRE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        count_d = count_inc;
        timer_d = timer_q + TMO_W'(1);
        if (count_hit || tmo_hit) begin
          state_d = ST_FIRE;
        end else if (!pending) begin
          state_d = ST_IDLE;
          count_d = '0;
          timer_d = '0;
        end
      end
      ST_FIRE: begin
        if (!pending) begin
          state_d = ST_IDLE;
          count_d = '0;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
    end
  end

  assign fire  = (state_q == ST_FIRE);
  assign count = count_q;

endmodule

// File: rtl/aq_axi_sdma64_intctl.sv
// rtl/aq_axi_sdma64_intctl.sv - sticky status/mask interrupt controller; coalescing under AQ_AXI_SDMA64_INTCTL_COALESCE_EN
module aq_axi_sdma64_intctl
  import aq_axi_sdma64_intctl_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] SRC_PULSE,
  input  logic               REG_WE,
  input  logic               REG_RE,
  input  logic [1:0]         REG_ADDR,
  input  logic [31:0]        REG_WDATA,
  output logic [31:0]        REG_RDATA,
  output logic               IRQ,
  output logic [CNT_W-1:0]   EVT_CNT
);

  logic [NUM_SRC-1:0] status_q, status_d, mask_q, mask_d, w1c;
  logic               gie_q, wr_status, wr_mask, wr_ctrl, irq_d;
  logic [31:0]        coal_cfg_rd, rd_mux;
  logic               unused_wdata;

  assign wr_status = REG_WE && (REG_ADDR == ADDR_STATUS);
  assign wr_mask   = REG_WE && (REG_ADDR == ADDR_MASK);
  assign wr_ctrl   = REG_WE && (REG_ADDR == ADDR_CTRL);

  // Pulse is OR-ed after the clear so a same-cycle set always wins.
  assign w1c      = wr_status ? REG_WDATA[NUM_SRC-1:0] : '0;
  assign status_d = (status_q & ~w1c) | SRC_PULSE;
  assign mask_d   = wr_mask ? REG_WDATA[NUM_SRC-1:0] : mask_q;
  assign unused_wdata = ^REG_WDATA;

`ifdef AQ_AXI_SDMA64_INTCTL_COALESCE_EN
  logic             wr_coal, evt, fire;
  logic [CNT_W-1:0] thr_q;
  logic [TMO_W-1:0] tmo_q;

  assign wr_coal = REG_WE && (REG_ADDR == ADDR_COAL_CFG);
  assign evt     = (|(SRC_PULSE & mask_q)) || (wr_ctrl && REG_WDATA[CTRL_FORCE]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      thr_q <= CNT_W'(THR_RST);
      tmo_q <= TMO_W'(TMO_RST);
    end else if (wr_coal) begin
      thr_q <= REG_WDATA[CNT_W-1:0];
      tmo_q <= REG_WDATA[16 +: TMO_W];
    end
  end

  // The FSM sees next-cycle pending so a W1C or mask clear returns it to IDLE on the same edge.
  aq_axi_sdma64_intctl_coal #(
    .CNT_W (CNT_W),
    .TMO_W (TMO_W)
  ) u_coal (
    .clk     (CLK),
    .rst     (RST),
    .evt     (evt),
    .pending (|(status_d & mask_d)),
    .thr     (thr_q),
    .tmo     (tmo_q),
    .fire    (fire),
    .count   (EVT_CNT)
  );

  assign coal_cfg_rd = 32'(thr_q) | (32'(tmo_q) << 16);
  assign irq_d       = fire & gie_q;
`else
  assign coal_cfg_rd = '0;
  assign EVT_CNT     = '0;
  assign irq_d       = gie_q & (|(status_q & mask_q));
`endif

  always_comb begin
    rd_mux = '0;
    case (REG_ADDR)
      ADDR_STATUS:   rd_mux = 32'(status_q);
      ADDR_MASK:     rd_mux = 32'(mask_q);
      ADDR_COAL_CFG: rd_mux = coal_cfg_rd;
      ADDR_CTRL:     rd_mux = {31'd0, gie_q};
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      status_q  <= '0;
      mask_q    <= '0;
      gie_q     <= 1'b0;
      IRQ       <= 1'b0;
      REG_RDATA <= '0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
      if (wr_ctrl) gie_q <= REG_WDATA[CTRL_GIE];
      IRQ <= irq_d;
      if (REG_RE) REG_RDATA <= rd_mux;
    end
  end

endmodule

// File: tb/tb_aq_axi_sdma64_intctl.sv
// tb/tb_aq_axi_sdma64_intctl.sv - directed self-checking bench for aq_axi_sdma64_intctl
module tb_aq_axi_sdma64_intctl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  SRC_PULSE = '0;
  logic        REG_WE = 1'b0;
  logic        REG_RE = 1'b0;
  logic [1:0]  REG_ADDR = '0;
  logic [31:0] REG_WDATA = '0;
  logic [31:0] REG_RDATA;
  logic        IRQ;
  logic [7:0]  EVT_CNT;

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] rd;

`ifdef AQ_AXI_SDMA64_INTCTL_COALESCE_EN
  localparam logic [31:0] COAL_RST_RD = 32'h0000_0001;
`else
  localparam logic [31:0] COAL_RST_RD = 32'h0000_0000;
`endif

  aq_axi_sdma64_intctl dut (
    .CLK       (CLK),
    .RST       (RST),
    .SRC_PULSE (SRC_PULSE),
    .REG_WE    (REG_WE),
    .REG_RE    (REG_RE),
    .REG_ADDR  (REG_ADDR),
    .REG_WDATA (REG_WDATA),
    .REG_RDATA (REG_RDATA),
    .IRQ       (IRQ),
    .EVT_CNT   (EVT_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
    REG_WE = 1'b1; REG_ADDR = addr; REG_WDATA = data;
    tick();
    REG_WE = 1'b0; REG_WDATA = '0;
  endtask

  task automatic reg_read(input logic [1:0] addr, output logic [31:0] data);
    REG_RE = 1'b1; REG_ADDR = addr;
    tick();
    REG_RE = 1'b0;
    data = REG_RDATA;
  endtask

  task automatic pulse(input logic [3:0] src);
    SRC_PULSE = src;
    tick();
    SRC_PULSE = '0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    chk("rst_rdata", REG_RDATA, 32'd0);
    chk("rst_evtcnt", {24'd0, EVT_CNT}, 32'd0);
    RST = 1'b0;
    tick();

    reg_read(2'd1, rd); chk("rst_mask", rd, 32'd0);
    reg_read(2'd2, rd); chk("rst_coal", rd, COAL_RST_RD);
    reg_read(2'd3, rd); chk("rst_ctrl", rd, 32'd0);
    reg_read(2'd0, rd); chk("rst_status", rd, 32'd0);

    reg_write(2'd1, 32'hF);
    reg_write(2'd3, 32'h1);
    pulse(4'b0100);
    chk("src2_irq_n", {31'd0, IRQ}, 32'd0);
    tick();
    chk("src2_irq_n1", {31'd0, IRQ}, 32'd1);
    reg_read(2'd0, rd); chk("src2_status", rd, 32'h4);
    reg_write(2'd0, 32'h4);
    chk("w1c_irq_m", {31'd0, IRQ}, 32'd1);
    tick();
    chk("w1c_irq_m1", {31'd0, IRQ}, 32'd0);
    reg_read(2'd0, rd); chk("w1c_status", rd, 32'h0);

    SRC_PULSE = 4'b0010;
    reg_write(2'd0, 32'h2);
    SRC_PULSE = '0;
    tick();
    chk("setwins_irq", {31'd0, IRQ}, 32'd1);
    reg_read(2'd0, rd); chk("setwins_status", rd, 32'h2);
    reg_write(2'd0, 32'h2);
    tick();
    chk("setwins_clr_irq", {31'd0, IRQ}, 32'd0);

    REG_RE = 1'b1;
    reg_write(2'd1, 32'h3);
    REG_RE = 1'b0;
    chk("rw_same_pre", REG_RDATA, 32'hF);
    reg_read(2'd1, rd); chk("rw_same_post", rd, 32'h3);
    reg_write(2'd1, 32'h0);

    pulse(4'b0001);
    tick();
    chk("masked_irq", {31'd0, IRQ}, 32'd0);
    reg_read(2'd0, rd); chk("masked_status", rd, 32'h1);
    reg_write(2'd1, 32'h1);
    reg_write(2'd3, 32'h3);
    tick();
    chk("force_irq", {31'd0, IRQ}, 32'd1);
    reg_read(2'd3, rd); chk("force_ctrl_rd", rd, 32'h1);
    reg_write(2'd1, 32'h0);
    tick();
    chk("maskclr_irq", {31'd0, IRQ}, 32'd0);
    chk("maskclr_evtcnt", {24'd0, EVT_CNT}, 32'd0);
    reg_write(2'd0, 32'h1);
    reg_write(2'd1, 32'hF);

`ifdef AQ_AXI_SDMA64_INTCTL_COALESCE_EN
    reg_write(2'd2, 32'h0000_0003);
    reg_read(2'd2, rd); chk("coal_cfg_rd", rd, 32'h3);
    pulse(4'b0011);
    chk("thr3_cnt1", {24'd0, EVT_CNT}, 32'd1);
    tick();
    pulse(4'b1000);
    chk("thr3_cnt2", {24'd0, EVT_CNT}, 32'd2);
    tick();
    chk("thr3_irq_low", {31'd0, IRQ}, 32'd0);
    pulse(4'b1000);
    chk("thr3_cnt3", {24'd0, EVT_CNT}, 32'd3);
    chk("thr3_irq_pre", {31'd0, IRQ}, 32'd0);
    tick();
    chk("thr3_irq", {31'd0, IRQ}, 32'd1);
    reg_write(2'd0, 32'hB);
    tick();
    chk("thr3_clr_irq", {31'd0, IRQ}, 32'd0);
    chk("thr3_clr_cnt", {24'd0, EVT_CNT}, 32'd0);

    reg_write(2'd2, 32'h000A_0008);
    pulse(4'b0001);
    repeat (10) tick();
    chk("tmo_irq_e10", {31'd0, IRQ}, 32'd0);
    tick();
    chk("tmo_irq_e11", {31'd0, IRQ}, 32'd1);
    chk("tmo_cnt", {24'd0, EVT_CNT}, 32'd1);
    reg_write(2'd0, 32'h1);
    tick();
    chk("tmo_clr_irq", {31'd0, IRQ}, 32'd0);
    reg_write(2'd2, 32'h0000_0001);
`endif

    pulse(4'b0100);
    tick();
    chk("prerst_irq", {31'd0, IRQ}, 32'd1);
    reg_read(2'd1, rd); chk("prerst_mask", rd, 32'hF);
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_irq", {31'd0, IRQ}, 32'd0);
    chk("midrst_rdata", REG_RDATA, 32'd0);
    chk("midrst_evtcnt", {24'd0, EVT_CNT}, 32'd0);
    tick();
    RST = 1'b0;
    reg_read(2'd0, rd); chk("postrst_status", rd, 32'd0);
    reg_read(2'd1, rd); chk("postrst_mask", rd, 32'd0);
    reg_read(2'd2, rd); chk("postrst_coal", rd, COAL_RST_RD);
    tick();
    chk("postrst_irq", {31'd0, IRQ}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
